// File: rtl/board_pkg.sv
// Shared types and constants for the board-game controller and its line scanner.
package board_pkg;

  typedef enum logic [1:0] {ST_PLAY, ST_SCAN, ST_OVER} state_t;

  // Scan directions, visited in declaration order.
  typedef enum logic [1:0] {DIR_E, DIR_S, DIR_SE, DIR_SW} dir_t;

  // Row / column step for each direction (indexed by dir_t).
  localparam logic signed [1:0] STEP_R [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
  localparam logic signed [1:0] STEP_C [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

  localparam int CELL_EMPTY = 0;

  // Cycles a full scan takes: 4 directions x 2 sides x (win_len-1) steps.
  function automatic int scan_cycles(input int win_len);
    return 8 * (win_len - 1);
  endfunction

endpackage

// File: rtl/board_line_scan.sv
// Sequential line scanner: walks E, S, SE, SW out from the placed cell, one
// probe per cycle, and reports whether any direction holds a winning run.
module board_line_scan
  import board_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIN_LEN = 4,
  parameter int CELL_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROWS*COLS*CELL_W-1:0] board,
  input  logic [7:0]                  origin,
  input  logic [CELL_W-1:0]           code,
  output logic                        done,
  output logic                        win
);

  // Probe coordinates wander up to WIN_LEN-1 cells off the board.
  localparam int CW    = 6;
  localparam int RUN_W = 6;
  // Steps taken on each side of the origin.
  localparam logic [3:0] LAST_STEP = 4'(scan_cycles(WIN_LEN) / 8);

  logic                  active, neg, stopped, win_acc;
  dir_t                  dir, dir_nx;
  logic [3:0]            step;
  logic [RUN_W-1:0]      run, run_next;
  logic signed [CW-1:0]  pr, pc;
  logic signed [CW-1:0]  org_r, org_c;
  logic signed [CW-1:0]  dr, dc, dr_nx, dc_nx;
  logic                  in_bounds, match, last_step, dir_win;
  logic [7:0]            probe_idx;
  logic [CELL_W-1:0]     probe_cell;

  assign org_r = CW'(int'(origin) / COLS);
  assign org_c = CW'(int'(origin) % COLS);

  assign dir_nx = dir_t'(dir + 2'd1);
  assign dr     = CW'(STEP_R[dir]);
  assign dc     = CW'(STEP_C[dir]);
  assign dr_nx  = CW'(STEP_R[dir_nx]);
  assign dc_nx  = CW'(STEP_C[dir_nx]);

  // Probe lookup, run accumulation and end-of-scan decode.
  always_comb begin
    in_bounds  = !pr[CW-1] && (pr < CW'(ROWS)) && !pc[CW-1] && (pc < CW'(COLS));
    probe_idx  = in_bounds ? 8'(int'(pr) * COLS + int'(pc)) : 8'd0;
    probe_cell = board[int'(probe_idx)*CELL_W +: CELL_W];
    match      = in_bounds && !stopped && (probe_cell == code);
    run_next   = run + RUN_W'(match);
    last_step  = (step == LAST_STEP);
    dir_win    = last_step && neg && (run_next >= RUN_W'(WIN_LEN));
    done       = active && last_step && neg && (dir == DIR_SW);
    win        = win_acc || dir_win;
  end

  // Walk state: direction, side, step count, probe position and run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      dir     <= DIR_E;
      neg     <= 1'b0;
      step    <= 4'd1;
      stopped <= 1'b0;
      run     <= RUN_W'(1);
      win_acc <= 1'b0;
      pr      <= '0;
      pc      <= '0;
    end else if (start) begin
      active  <= 1'b1;
      dir     <= DIR_E;
      neg     <= 1'b0;
      step    <= 4'd1;
      stopped <= 1'b0;
      run     <= RUN_W'(1);
      win_acc <= 1'b0;
      pr      <= org_r + CW'(STEP_R[DIR_E]);
      pc      <= org_c + CW'(STEP_C[DIR_E]);
    end else if (active) begin
      run <= run_next;
      if (!match) stopped <= 1'b1;
      if (!last_step) begin
        step <= step + 4'd1;
        pr   <= neg ? pr - dr : pr + dr;
        pc   <= neg ? pc - dc : pc + dc;
      end else if (!neg) begin
        // Positive side finished: restart from the origin going backwards.
        neg     <= 1'b1;
        step    <= 4'd1;
        stopped <= 1'b0;
        pr      <= org_r - dr;
        pc      <= org_c - dc;
      end else begin
        // Direction finished: latch its verdict and move to the next one.
        win_acc <= win_acc | dir_win;
        neg     <= 1'b0;
        step    <= 4'd1;
        stopped <= 1'b0;
        run     <= RUN_W'(1);
        if (dir == DIR_SW) begin
          active <= 1'b0;
        end else begin
          dir <= dir_nx;
          pr  <= org_r + dr_nx;
          pc  <= org_c + dc_nx;
        end
      end
    end
  end

endmodule

// File: rtl/board_game_ctrl.sv
// Game-board controller: cursor, placement, turn order and win/draw detection.
// Optional build macro CURSOR_SKIP_EN: move jumps to the next empty cell.
module board_game_ctrl
  import board_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int WIN_LEN     = 4,
  parameter int CELL_W      = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        move,
  input  logic                        select,
  output logic [ROWS*COLS*CELL_W-1:0] cells,
  output logic [7:0]                  cursor,
  output logic [2:0]                  player,
  output logic [7:0]                  counter,
  output logic                        busy,
  output logic                        invalid,
  output logic                        game_over,
  output logic [CELL_W-1:0]           winner,
  output logic                        draw
);

  localparam int         NCELLS      = ROWS * COLS;
  localparam logic [7:0] LAST_CELL   = 8'(NCELLS - 1);
  localparam logic [2:0] LAST_PLAYER = 3'(NUM_PLAYERS - 1);

  state_t                      state, state_n;
  logic [ROWS*COLS*CELL_W-1:0] cells_n;
  logic [7:0]                  cursor_n, counter_n, cursor_adv;
  logic [2:0]                  player_n;
  logic                        busy_n, invalid_n, game_over_n, draw_n;
  logic [CELL_W-1:0]           winner_n, code, cur_cell;
  logic                        scan_start, scan_done, scan_win;

  assign code     = CELL_W'(player + 3'd1);
  assign cur_cell = cells[int'(cursor)*CELL_W +: CELL_W];

  board_line_scan #(
    .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .CELL_W(CELL_W)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (scan_start),
    .board  (cells_n),
    .origin (cursor),
    .code   (code),
    .done   (scan_done),
    .win    (scan_win)
  );

`ifdef CURSOR_SKIP_EN
  // Next empty cell after the cursor, row-major with wrap; stay put if none.
  always_comb begin
    int   idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    cursor_adv = cursor;
    for (int k = 1; k < NCELLS; k++) begin
      idx = (int'(cursor) + k) % NCELLS;
      if (!found && cells[idx*CELL_W +: CELL_W] == CELL_W'(CELL_EMPTY)) begin
        cursor_adv = 8'(idx);
        found      = 1'b1;
      end
    end
  end
`else
  // Plain increment with wrap.
  assign cursor_adv = (cursor == LAST_CELL) ? 8'd0 : cursor + 8'd1;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    cells_n     = cells;
    cursor_n    = cursor;
    player_n    = player;
    counter_n   = counter;
    busy_n      = busy;
    invalid_n   = 1'b0;
    game_over_n = game_over;
    winner_n    = winner;
    draw_n      = draw;
    scan_start  = 1'b0;
    case (state)
      ST_PLAY: begin
        // select has priority; a simultaneous move is dropped.
        if (select) begin
          if (cur_cell == CELL_W'(CELL_EMPTY)) begin
            cells_n[int'(cursor)*CELL_W +: CELL_W] = code;
            counter_n  = counter + 8'd1;
            busy_n     = 1'b1;
            scan_start = 1'b1;
            state_n    = ST_SCAN;
          end else begin
            invalid_n = 1'b1;
          end
        end else if (move) begin
          cursor_n = cursor_adv;
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          busy_n = 1'b0;
          if (scan_win) begin
            winner_n    = code;
            game_over_n = 1'b1;
            state_n     = ST_OVER;
          end else if (counter == 8'(NCELLS)) begin
            draw_n      = 1'b1;
            game_over_n = 1'b1;
            state_n     = ST_OVER;
          end else begin
            player_n = (player == LAST_PLAYER) ? 3'd0 : player + 3'd1;
            state_n  = ST_PLAY;
          end
        end
      end
      ST_OVER: begin
        if (select) begin
          cells_n     = '0;
          cursor_n    = 8'd0;
          player_n    = 3'd0;
          counter_n   = 8'd0;
          game_over_n = 1'b0;
          winner_n    = '0;
          draw_n      = 1'b0;
          state_n     = ST_PLAY;
        end
      end
      default: state_n = ST_PLAY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_PLAY;
    else     state <= state_n;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cells     <= '0;
      cursor    <= 8'd0;
      player    <= 3'd0;
      counter   <= 8'd0;
      busy      <= 1'b0;
      invalid   <= 1'b0;
      game_over <= 1'b0;
      winner    <= '0;
      draw      <= 1'b0;
    end else begin
      cells     <= cells_n;
      cursor    <= cursor_n;
      player    <= player_n;
      counter   <= counter_n;
      busy      <= busy_n;
      invalid   <= invalid_n;
      game_over <= game_over_n;
      winner    <= winner_n;
      draw      <= draw_n;
    end
  end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Directed scoreboard bench for board_game_ctrl at default 4x4, 2 players, WIN_LEN 4.
module tb_board_game_ctrl;

  localparam int ROWS = 4, COLS = 4, NP = 2, WL = 4, CW = 2, N = 16, S = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1, move = 1'b0, select = 1'b0;
  logic [N*CW-1:0] cells;
  logic [7:0]      cursor, counter;
  logic [2:0]      player;
  logic            busy, invalid, game_over, draw;
  logic [CW-1:0]   winner;

  board_game_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .NUM_PLAYERS(NP), .WIN_LEN(WL)
  ) dut (
    .clk(clk), .rst(rst), .move(move), .select(select),
    .cells(cells), .cursor(cursor), .player(player), .counter(counter),
    .busy(busy), .invalid(invalid), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  logic [63:0]     exp_q[$];
  int              n_checks = 0, n_errors = 0;
  int              cur = 0;
  logic [N*CW-1:0] mboard = '0;
  int              cyc;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic pulse_move();
    move = 1'b1; tick(); move = 1'b0;
    cur = (cur + 1) % N;
  endtask

  task automatic move_to(input int idx);
    while (cur != idx) pulse_move();
  endtask

  // Counts cycles with busy high, bounded so a stuck scan still terminates.
  task automatic wait_scan(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cur = 0; mboard = '0;
  endtask

  task automatic check_reset_vals(input string p);
    expect_v(0); chk({p, "_cells"}, 64'(cells));
    expect_v(0); chk({p, "_cursor"}, 64'(cursor));
    expect_v(0); chk({p, "_player"}, 64'(player));
    expect_v(0); chk({p, "_counter"}, 64'(counter));
    expect_v(0); chk({p, "_flags"}, 64'({busy, invalid, game_over, draw}));
    expect_v(0); chk({p, "_winner"}, 64'(winner));
  endtask

  task automatic place(input int idx, input int code);
    int n;
    move_to(idx);
    select = 1'b1; tick(); select = 1'b0;
    mboard[idx*CW +: CW] = CW'(code);
    expect_v(64'(mboard)); chk("place_cells", 64'(cells));
    wait_scan(n);
    expect_v(S); chk("place_busy_len", 64'(n));
  endtask

  initial begin
    int win_seq[7];
    int draw_seq[16];
    win_seq  = '{0, 4, 1, 5, 2, 6, 3};
    draw_seq = '{0, 2, 1, 3, 6, 4, 7, 5, 8, 10, 9, 11, 14, 12, 15, 13};

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Cursor walk and wrap
    repeat (15) pulse_move();
    expect_v(15); chk("cursor_15", 64'(cursor));
    pulse_move();
    expect_v(0); chk("cursor_wrap", 64'(cursor));

    // First placement and scan latency
    select = 1'b1; tick(); select = 1'b0;
    mboard[1:0] = 2'd1;
    expect_v(64'(mboard)); chk("sel0_cells", 64'(cells));
    expect_v(1); chk("sel0_counter", 64'(counter));
    expect_v(1); chk("sel0_busy", 64'(busy));
    wait_scan(cyc);
    expect_v(S); chk("sel0_busy_len", 64'(cyc));
    expect_v(1); chk("sel0_player", 64'(player));
    expect_v(0); chk("sel0_game_over", 64'(game_over));

    // Select on occupied cell
    select = 1'b1; tick(); select = 1'b0;
    expect_v(1); chk("invalid_pulse", 64'(invalid));
    tick();
    expect_v(0); chk("invalid_clear", 64'(invalid));
    expect_v(64'(mboard)); chk("invalid_cells", 64'(cells));
    expect_v(1); chk("invalid_counter", 64'(counter));
    expect_v(1); chk("invalid_player", 64'(player));

    // Move+select together: placement wins, cursor holds
    pulse_move();
    move = 1'b1; select = 1'b1; tick(); move = 1'b0; select = 1'b0;
    mboard[3:2] = 2'd2;
    expect_v(64'(mboard)); chk("movesel_cells", 64'(cells));
    expect_v(1); chk("movesel_cursor", 64'(cursor));
    // Pulses during the scan are dropped
    move = 1'b1; select = 1'b1; tick(); move = 1'b0; select = 1'b0;
    wait_scan(cyc);
    expect_v(1); chk("scan_ignore_cursor", 64'(cursor));
    expect_v(2); chk("scan_ignore_counter", 64'(counter));
    expect_v(0); chk("scan_ignore_player", 64'(player));

    // Row win for player 0
    do_reset();
    for (int i = 0; i < 7; i++) place(win_seq[i], (i % 2) + 1);
    expect_v(1); chk("win_winner", 64'(winner));
    expect_v(1); chk("win_game_over", 64'(game_over));
    expect_v(0); chk("win_draw", 64'(draw));
    expect_v(0); chk("win_player", 64'(player));
    move = 1'b1; tick(); move = 1'b0;
    expect_v(3); chk("over_move_ignored", 64'(cursor));
    select = 1'b1; tick(); select = 1'b0;
    cur = 0; mboard = '0;
    check_reset_vals("restart");

    // Full board, no run of four
    for (int i = 0; i < 16; i++) place(draw_seq[i], (i % 2) + 1);
    expect_v(1); chk("draw_flag", 64'(draw));
    expect_v(0); chk("draw_winner", 64'(winner));
    expect_v(1); chk("draw_game_over", 64'(game_over));
    expect_v(16); chk("draw_counter", 64'(counter));

    // Reset in the middle of a scan
    do_reset();
    select = 1'b1; tick(); select = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("midscan_rst");
    repeat (30) tick();
    expect_v(0); chk("midscan_late_flags", 64'({busy, game_over, draw}));
    expect_v(0); chk("midscan_late_player", 64'(player));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/board_game_ctrl.md
# board_game_ctrl

Parametrised game-board controller for the VGA board-game top level. It is the next generation of the fixed 4x4, two-player move/select engine. It holds a ROWS x COLS board of cell codes, a cursor, the turn player and a placement counter. After every placement it runs a fixed-latency sequential line scan to detect a win or a draw. It sits between the debounced push-button pulses and the VGA renderer and 7-segment decoders.

## Interface
- ROWS, 4, board rows (2..15)
- COLS, 4, board columns (2..15); ROWS*COLS ≤ 255
- NUM_PLAYERS, 2, players (2..7)
- WIN_LEN, 4, run length that wins (2..min(ROWS,COLS))
- CELL_W, $clog2(NUM_PLAYERS+1), derived width of a cell code; do not override
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- move  in  1  debounced single-cycle pulse, advances cursor
- select  in  1  debounced single-cycle pulse, places mark / restarts
- cells  out  ROWS*COLS*CELL_W  board, cell i at bits [i*CELL_W +: CELL_W], row-major; 0 = empty, p+1 = player p
- cursor  out  8  cursor cell index, row-major
- player  out  3  player whose turn it is (0-based)
- counter  out  8  placements made this game
- busy  out  1  scan in progress
- invalid  out  1  one-cycle pulse: select on occupied cell
- game_over  out  1  game finished
- winner  out  CELL_W  winning cell code; 0 = none
- draw  out  1  board full, no winner

## Operation
- States: PLAY, SCAN, OVER.
- Reset values: all cells 0, cursor 0, player 0, counter 0, busy 0, invalid 0, game_over 0, winner 0, draw 0, state PLAY.
- PLAY, select, cursor cell empty: write player+1 to the cell, counter+1, go to SCAN. The cursor does not move.
- PLAY, select, cursor cell occupied: invalid=1 for one cycle, no other change.
- PLAY, move, no select: cursor+1, wraps from ROWS*COLS-1 to 0.
- PLAY, move and select in the same cycle: select wins, move is dropped.
- SCAN: the four directions (E, S, SE, SW) are scanned in order. Each direction takes 2*(WIN_LEN-1) cycles:
  - WIN_LEN-1 steps in the positive direction, then WIN_LEN-1 steps in the negative direction.
  - Run = 1 + consecutive matching cells on both sides.
  - A step off the board or onto a non-matching cell stops counting on that side. The remaining steps on that side still consume their cycles.
  - Win if run ≥ WIN_LEN in any direction.
- SCAN end, win: winner=placed code, game_over=1, go to OVER. Win beats draw on the last cell.
- SCAN end, counter == ROWS*COLS and no win: draw=1, game_over=1, go to OVER.
- SCAN end, otherwise: player+1 (wraps at NUM_PLAYERS-1 to 0), go to PLAY.
- In SCAN, move and select are ignored; no pulses are queued.
- In OVER, move is ignored. Select restarts: every output returns to its reset value, state PLAY.
- Reset mid-SCAN abandons the scan. No partial result is visible after the reset edge.

## Timing
- Accepted select sampled at edge t: cell, counter and busy=1 visible after edge t.
- busy stays high exactly S = 8*(WIN_LEN-1) cycles. Result (player, or winner/draw/game_over) is visible after edge t+S; busy=0 at the same edge.
- move: cursor updates after the sampling edge; one step per pulse.
- invalid is high for the cycle after the offending select edge.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- CURSOR_SKIP_EN defined: move jumps to the next empty cell after the cursor, row-major with wrap. If no other cell is empty, the cursor is unchanged.
- CURSOR_SKIP_EN undefined: plain +1 with wrap, as in Operation.

## Structure
- Package board_pkg holds:
  - state enum (PLAY, SCAN, OVER)
  - direction enum and per-direction row/column step constants
  - CELL_EMPTY = 0
  - function computing SCAN_CYCLES from WIN_LEN
- Sub-module board_line_scan holds the direction/step counters, coordinate walk, bounds check and run accumulator. It takes the board, origin index and code, plus a start pulse. It returns done and win.

## Test plan
Defaults 4x4, 2 players, WIN_LEN 4, S=24.
- Reset → cells 0, cursor 0, player 0, counter 0, every flag 0.
- 15 move pulses → cursor 15; 16th → cursor 0. With CURSOR_SKIP_EN and cells 1,2 occupied, one move from 0 → cursor 3.
- Select at cursor 0 → cell0=1, counter=1, busy high exactly 24 cycles, then player=1, game_over=0.
- Select on occupied cell 0 → invalid pulses 1 cycle; cells, counter and player unchanged. Move+select on an empty cell → placement happens, cursor unchanged.
- P0 places 0,1,2,3, P1 places 4,5,6 interleaved → after 7th scan winner=1, game_over=1. Move is ignored; select → full reset state.
- Fill the board with no 4-run (rows 1122/2211/1122/2211) → after 16th scan draw=1, winner=0. Separately, rst pulse 5 cycles into a scan → reset values, busy=0.
